// File: rtl/mem_write.sv
// ---------------------------------------------------------------------------
// mem_write -- SPI (mode 0) page-program style write master.
//
// On a start request in IDLE it latches the address, data and size, then
// serialises command 0x02, a 24-bit address (MSB byte first) and 1, 2 or 4
// data bytes (little-endian byte order, each byte MSB first). sclk runs at
// clk/2. mosi only changes on the edge that drives sclk low. One extra cycle
// of chip-select hold follows the last bit, then write_done is raised. It
// stays high until start_write is seen low.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   synchronous active-low reset
//   start_write    in   level request, sampled in IDLE
//   target_address in   [23:0] byte address, latched at start
//   write_data     in   [31:0] store data, latched at start (byte 0 = [7:0])
//   write_size     in   [1:0] 00 = 1 byte, 01 = 2 bytes, 1x = 4 bytes
//   write_done     out  completion flag
//   busy           out  transaction in progress
//   sclk           out  SPI clock
//   mosi           out  SPI data out
//   cs             out  SPI chip select, active-low
// ---------------------------------------------------------------------------
module mem_write (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_write,
    input  logic [23:0] target_address,
    input  logic [31:0] write_data,
    input  logic [1:0]  write_size,
    output logic        write_done,
    output logic        busy,
    output logic        sclk,
    output logic        mosi,
    output logic        cs
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Index of the final bit in the stream: 32 + 8*N - 1.
    localparam logic [6:0] LAST_BYTE = 7'd39;
    localparam logic [6:0] LAST_HALF = 7'd47;
    localparam logic [6:0] LAST_WORD = 7'd63;

    state_t      state_q,    state_d;
    logic [6:0]  bit_cnt_q,  bit_cnt_d;
    logic [6:0]  last_bit_q, last_bit_d;
    logic [63:0] shreg_q,    shreg_d;
    logic        cs_q,       cs_d;
    logic        sclk_q,     sclk_d;
    logic        mosi_q,     mosi_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;

    // Full stream, left-aligned so the current bit is always shreg[63].
    // Byte writes only ever shift out the first data byte.
    logic [63:0] load_vec;
    assign load_vec = {8'h02, target_address,
                       write_data[7:0],   write_data[15:8],
                       write_data[23:16], write_data[31:24]};

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the
        // case below can leave one unassigned and infer a latch.
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        last_bit_d = last_bit_q;
        shreg_d    = shreg_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = done_q;

        unique case (state_q)
            IDLE: begin
                if (start_write) begin
                    shreg_d   = load_vec;
                    bit_cnt_d = 7'd0;
                    unique case (write_size)
                        2'b00:   last_bit_d = LAST_BYTE;
                        2'b01:   last_bit_d = LAST_HALF;
                        default: last_bit_d = LAST_WORD;
                    endcase
                    cs_d    = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = load_vec[63];
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (!sclk_q) begin
                    // Low phase ends: raise sclk, mosi held.
                    sclk_d = 1'b1;
                end else if (bit_cnt_q == last_bit_q) begin
                    // Last high phase ends: sclk low, hold cs one more cycle.
                    sclk_d  = 1'b0;
                    state_d = FINISH;
                end else begin
                    // Falling sclk is the only point mosi advances.
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q + 7'd1;
                    shreg_d   = {shreg_q[62:0], 1'b0};
                    mosi_d    = shreg_q[62];
                end
            end

            FINISH: begin
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end

            DONE: begin
                // A held request keeps the flag up and cannot retrigger.
                if (!start_write) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 7'd0;
            last_bit_q <= LAST_WORD;
            shreg_q    <= 64'd0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the values
            // from before this edge, regardless of statement order.
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            last_bit_q <= last_bit_d;
            shreg_q    <= shreg_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign write_done = done_q;
    assign busy       = busy_q;
    assign sclk       = sclk_q;
    assign mosi       = mosi_q;
    assign cs         = cs_q;

endmodule

// File: tb/tb_mem_write.sv
// ---------------------------------------------------------------------------
// tb_mem_write -- directed bench for mem_write.
// Each transaction is started, the mosi stream is captured on every sclk
// rise, and timing is measured in edges after the latch edge E0. Expected
// streams and edge numbers are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_mem_write;

    logic        clk;
    logic        rst_n;
    logic        start_write;
    logic [23:0] target_address;
    logic [31:0] write_data;
    logic [1:0]  write_size;
    logic        write_done;
    logic        busy;
    logic        sclk;
    logic        mosi;
    logic        cs;

    int compared   = 0;
    int mismatched = 0;

    mem_write dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_write    (start_write),
        .target_address (target_address),
        .write_data     (write_data),
        .write_size     (write_size),
        .write_done     (write_done),
        .busy           (busy),
        .sclk           (sclk),
        .mosi           (mosi),
        .cs             (cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one transaction. Inputs are driven away from the edge; outputs are
    // sampled #1 after each rising edge. Edge n means E0+n.
    task automatic run_txn(input string tag, input logic [23:0] a,
                           input logic [31:0] d, input logic [1:0] s,
                           input int nbits, input logic [63:0] exp_bits,
                           input logic mid_change, input logic hold_start);
        logic [63:0] cap;
        int          ncap, done_edge, cs_edge, viol, edge_n;
        logic        prev_sclk, prev_mosi, fin_sclk, fin_cs, busy_at_done;
        cap = 64'd0; ncap = 0; done_edge = -1; cs_edge = -1; viol = 0;
        fin_sclk = 1'bx; fin_cs = 1'bx; busy_at_done = 1'bx;

        @(negedge clk);
        target_address = a;
        write_data     = d;
        write_size     = s;
        start_write    = 1'b1;
        @(posedge clk); #1;                       // E0
        check({tag, " E0 cs"},   64'(cs),   64'd0);
        check({tag, " E0 busy"}, 64'(busy), 64'd1);
        check({tag, " E0 sclk"}, 64'(sclk), 64'd0);
        check({tag, " E0 mosi"}, 64'(mosi), 64'd0);   // MSB of 0x02
        prev_sclk = sclk;
        prev_mosi = mosi;

        edge_n = 0;
        while (done_edge < 0 && edge_n < 400) begin
            @(posedge clk); #1;
            edge_n++;
            if (!hold_start && edge_n == 1) start_write = 1'b0;
            if (mid_change && edge_n == 10) begin
                target_address = 24'hFFFFFF;
                write_data     = 32'h5A5A5A5A;
                write_size     = 2'b00;
            end
            if (sclk && !prev_sclk && !cs) begin
                cap = {cap[62:0], mosi};
                ncap++;
            end
            if (mosi !== prev_mosi && sclk) viol++;      // mosi moved off a fall
            if (cs && (sclk || mosi)) viol++;            // idle lines not quiet
            if (edge_n == 2 * nbits) begin
                fin_sclk = sclk;
                fin_cs   = cs;
            end
            if (cs && cs_edge < 0) cs_edge = edge_n;
            if (write_done) begin
                done_edge    = edge_n;
                busy_at_done = busy;
            end
            prev_sclk = sclk;
            prev_mosi = mosi;
        end

        check({tag, " done seen in budget"}, 64'(done_edge >= 0), 64'd1);
        check({tag, " bit count"}, 64'(ncap), 64'(nbits));
        check({tag, " bit stream"}, cap, exp_bits);
        check({tag, " finish sclk"}, 64'(fin_sclk), 64'd0);
        check({tag, " finish cs"},   64'(fin_cs),   64'd0);
        check({tag, " done edge"}, 64'(done_edge), 64'(2 * nbits + 1));
        check({tag, " cs rise edge"}, 64'(cs_edge), 64'(2 * nbits + 1));
        check({tag, " busy at done"}, 64'(busy_at_done), 64'd0);
        check({tag, " line rules"}, 64'(viol), 64'd0);

        if (hold_start) begin
            // Keep start high until 300 cycles after E0.
            viol = 0;
            for (int i = done_edge + 1; i < 300; i++) begin
                @(posedge clk); #1;
                if (!write_done || !cs || busy || sclk || mosi) viol++;
            end
            check({tag, " held done/no retrigger"}, 64'(viol), 64'd0);
            @(negedge clk);
            start_write = 1'b0;
            @(posedge clk); #1;
            check({tag, " done clears"}, 64'(write_done), 64'd0);
            @(posedge clk); #1;
            check({tag, " cs idle after"}, 64'(cs), 64'd1);
        end else begin
            @(posedge clk); #1;
            check({tag, " done one cycle"}, 64'(write_done), 64'd0);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        start_write    = 1'b1;        // must be ignored under reset
        target_address = 24'h0;
        write_data     = 32'h0;
        write_size     = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset cs",   64'(cs),         64'd1);
        check("reset sclk", 64'(sclk),       64'd0);
        check("reset mosi", 64'(mosi),       64'd0);
        check("reset busy", 64'(busy),       64'd0);
        check("reset done", 64'(write_done), 64'd0);
        @(negedge clk);
        start_write = 1'b0;
        rst_n       = 1'b1;
        repeat (2) @(posedge clk);

        // Word write.
        run_txn("word", 24'h000104, 32'hDEADBEEF, 2'b10, 64,
                64'h02000104EFBEADDE, 1'b0, 1'b0);
        // Byte write: upper data bytes never sent.
        run_txn("byte", 24'hABCDEF, 32'h12345678, 2'b00, 40,
                64'h00000002ABCDEF78, 1'b0, 1'b0);
        // Half-word with inputs disturbed mid-transfer.
        run_txn("half", 24'h000010, 32'h0000BEEF, 2'b01, 48,
                64'h000002000010EFBE, 1'b1, 1'b0);
        // Size 11 behaves as a word.
        run_txn("size11", 24'h123456, 32'hCAFEF00D, 2'b11, 64,
                64'h021234560DF0FECA, 1'b0, 1'b0);

        // Reset at E0+40 of a word write.
        @(negedge clk);
        target_address = 24'h000104;
        write_data     = 32'hDEADBEEF;
        write_size     = 2'b10;
        start_write    = 1'b1;
        @(posedge clk); #1;                       // E0
        start_write = 1'b0;
        repeat (39) @(posedge clk);               // E0+39
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;                       // E0+40
        check("abort cs",   64'(cs),         64'd1);
        check("abort sclk", 64'(sclk),       64'd0);
        check("abort busy", 64'(busy),       64'd0);
        check("abort done", 64'(write_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort no late done", 64'(write_done), 64'd0);
        run_txn("post-abort word", 24'h000104, 32'hDEADBEEF, 2'b10, 64,
                64'h02000104EFBEADDE, 1'b0, 1'b0);

        // start_write held high for 300 cycles.
        run_txn("held", 24'h000104, 32'hDEADBEEF, 2'b10, 64,
                64'h02000104EFBEADDE, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
